// File: rtl/cu_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
package cu_pkg;

    typedef enum logic [3:0] {
        NOP  = 4'd0,
        IN   = 4'd1,
        OUT  = 4'd2,
        MOV  = 4'd3,
        SHL  = 4'd4,
        SHR  = 4'd5,
        INCA = 4'd6,
        INCB = 4'd7,
        ADD  = 4'd8,
        SUB  = 4'd9,
        AND  = 4'd10,
        OR   = 4'd11
    } opcode_e;

    localparam logic [3:0] F_PASSA = 4'b0000;
    localparam logic [3:0] F_PASSB = 4'b0001;
    localparam logic [3:0] F_INCA  = 4'b0010;
    localparam logic [3:0] F_INCB  = 4'b0011;
    localparam logic [3:0] F_ADD   = 4'b0100;
    localparam logic [3:0] F_SUB   = 4'b0101;
    localparam logic [3:0] F_AND   = 4'b0110;
    localparam logic [3:0] F_OR    = 4'b0111;
    localparam logic [3:0] F_SHR   = 4'b1000;
    localparam logic [3:0] F_SHL   = 4'b1001;

    localparam logic [1:0] BSEL_REG  = 2'b00;
    localparam logic [1:0] BSEL_ZERO = 2'b01;
    localparam logic [1:0] BSEL_EXT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Opcodes 1100-1111 are reserved and rejected.
    function automatic logic is_illegal(input logic [3:0] op);
        return op[3] & op[2];
    endfunction

endpackage

// File: rtl/btn_press_detect.sv
// Falling-edge detector for the active-low execute button; one-cycle press pulse.
module btn_press_detect (
    input  logic clk,
    input  logic rstn,
    input  logic btn_i,
    output logic press_o
);

    logic btn_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            btn_q <= 1'b1;
        end else begin
            btn_q <= btn_i;
        end
    end

    assign press_o = btn_q & ~btn_i;

endmodule

// File: rtl/param_control_unit.sv
// Multi-cycle control unit: latches an instruction on a button press and sequences
// ALU, B-mux and register-file enables, including repeated shifts.
module param_control_unit
    import cu_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 4,
    parameter int unsigned MAX_SHIFT = 7,
    localparam int unsigned RAW      = $clog2(NUM_REGS),
    localparam int unsigned SHW      = $clog2(MAX_SHIFT + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                ex_btn,
    input  logic [3:0]          opcode,
    input  logic [RAW-1:0]      rd_sel,
    input  logic [RAW-1:0]      rs_sel,
    input  logic [SHW-1:0]      shamt,
    output logic [RAW-1:0]      a_sel,
    output logic [RAW-1:0]      b_reg_sel,
    output logic [1:0]          B_sel,
    output logic [3:0]          F_sel,
    output logic [NUM_REGS-1:0] write_en,
    output logic                write_o,
    output logic                busy,
    output logic                done,
    output logic                illegal
);

    state_e         state_q, state_d;
    opcode_e        op_q, op_d;
    logic [RAW-1:0] rd_q, rd_d;
    logic [RAW-1:0] rs_q, rs_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic           illegal_q, illegal_d;
    logic           press;
    logic           is_shift;
    logic           wr_rd;

    btn_press_detect u_press (
        .clk     (clk),
        .rstn    (rstn),
        .btn_i   (ex_btn),
        .press_o (press)
    );

    assign is_shift = (op_q == SHL) || (op_q == SHR);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            op_q      <= NOP;
            rd_q      <= '0;
            rs_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (press) begin
                    if (is_illegal(opcode)) begin
                        illegal_d = 1'b1;
                    end else begin
                        op_d    = opcode_e'(opcode);
                        rd_d    = rd_sel;
                        rs_d    = rs_sel;
                        cnt_d   = shamt;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                // Shifts stay until the count reaches one; shamt==0 leaves after one cycle.
                if (is_shift && (cnt_q > SHW'(1))) begin
                    cnt_d = cnt_q - SHW'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_sel     = '0;
        b_reg_sel = '0;
        B_sel     = BSEL_ZERO;
        F_sel     = F_PASSA;
        write_en  = '0;
        write_o   = 1'b0;
        wr_rd     = 1'b0;
        if (state_q == EXEC) begin
            a_sel     = rd_q;
            b_reg_sel = rs_q;
            case (op_q)
                NOP: ;
                IN: begin
                    B_sel = BSEL_EXT;
                    F_sel = F_PASSB;
                    wr_rd = 1'b1;
                end
                OUT: write_o = 1'b1;
                MOV: begin
                    a_sel = rs_q;
                    wr_rd = 1'b1;
                end
                SHL: begin
                    F_sel = F_SHL;
                    wr_rd = (cnt_q != '0);
                end
                SHR: begin
                    F_sel = F_SHR;
                    wr_rd = (cnt_q != '0);
                end
                INCA: begin
                    F_sel = F_INCA;
                    wr_rd = 1'b1;
                end
                INCB: begin
                    B_sel = BSEL_REG;
                    F_sel = F_INCB;
                    wr_rd = 1'b1;
                end
                ADD: begin
                    B_sel = BSEL_REG;
                    F_sel = F_ADD;
                    wr_rd = 1'b1;
                end
                SUB: begin
                    B_sel = BSEL_REG;
                    F_sel = F_SUB;
                    wr_rd = 1'b1;
                end
                AND: begin
                    B_sel = BSEL_REG;
                    F_sel = F_AND;
                    wr_rd = 1'b1;
                end
                OR: begin
                    B_sel = BSEL_REG;
                    F_sel = F_OR;
                    wr_rd = 1'b1;
                end
                default: ;
            endcase
            if (wr_rd) begin
                write_en[rd_q] = 1'b1;
            end
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_param_control_unit.sv
// Scoreboard bench: stimulus pushes expected per-cycle outputs, a negedge monitor compares.
module tb_param_control_unit;

    logic       clk;
    logic       rstn;
    logic       ex_btn;
    logic [3:0] opcode;
    logic [1:0] rd_sel;
    logic [1:0] rs_sel;
    logic [2:0] shamt;
    logic [1:0] a_sel;
    logic [1:0] b_reg_sel;
    logic [1:0] B_sel;
    logic [3:0] F_sel;
    logic [3:0] write_en;
    logic       write_o;
    logic       busy;
    logic       done;
    logic       illegal;

    param_control_unit #(
        .NUM_REGS  (4),
        .MAX_SHIFT (7)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ex_btn    (ex_btn),
        .opcode    (opcode),
        .rd_sel    (rd_sel),
        .rs_sel    (rs_sel),
        .shamt     (shamt),
        .a_sel     (a_sel),
        .b_reg_sel (b_reg_sel),
        .B_sel     (B_sel),
        .F_sel     (F_sel),
        .write_en  (write_en),
        .write_o   (write_o),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal)
    );

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       illegal;
        logic [1:0] a_sel;
        logic [1:0] b_reg_sel;
        logic [1:0] b_sel;
        logic [3:0] f_sel;
        logic [3:0] write_en;
        logic       write_o;
    } rec_t;

    localparam rec_t IDLE_REC = '{busy: 1'b0, done: 1'b0, illegal: 1'b0, a_sel: 2'd0,
                                  b_reg_sel: 2'd0, b_sel: 2'b01, f_sel: 4'd0,
                                  write_en: 4'd0, write_o: 1'b0};

    rec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic mon_en   = 1'b0;
    logic end_req  = 1'b0;
    logic end_ack  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: the cycle-by-cycle output trace of one accepted instruction.
    function automatic rec_t exec_rec(input int op, input int rd, input int rs, input bit wr_ok);
        rec_t r;
        bit   wr;
        r = IDLE_REC;
        r.busy = 1'b1;
        r.a_sel = 2'(rd);
        r.b_reg_sel = 2'(rs);
        wr = 1'b1;
        case (op)
            0: wr = 1'b0;
            1: begin r.b_sel = 2'b11; r.f_sel = 4'b0001; end
            2: begin r.write_o = 1'b1; wr = 1'b0; end
            3: r.a_sel = 2'(rs);
            4: begin r.f_sel = 4'b1001; wr = wr_ok; end
            5: begin r.f_sel = 4'b1000; wr = wr_ok; end
            6: r.f_sel = 4'b0010;
            7: begin r.b_sel = 2'b00; r.f_sel = 4'b0011; end
            default: begin r.b_sel = 2'b00; r.f_sel = 4'(4 + op - 8); end
        endcase
        if (wr) r.write_en = 4'(1 << rd);
        return r;
    endfunction

    task automatic push_expect(input int op, input int rd, input int rs, input int sh,
                               output int len);
        rec_t r;
        int   n;
        if (op >= 12) begin
            r = IDLE_REC;
            r.illegal = 1'b1;
            exp_q.push_back(r);
            len = 1;
        end else begin
            n = ((op == 4 || op == 5) && sh > 0) ? sh : 1;
            for (int i = 0; i < n; i++) exp_q.push_back(exec_rec(op, rd, rs, sh > 0));
            r = IDLE_REC;
            r.busy = 1'b1;
            r.done = 1'b1;
            exp_q.push_back(r);
            len = n + 1;
        end
    endtask

    // Called just after a negedge; the press is sampled at the following posedge.
    task automatic do_instr(input int op, input int rd, input int rs, input int sh,
                            input int hold, input int gap);
        int len;
        push_expect(op, rd, rs, sh, len);
        opcode = 4'(op);
        rd_sel = 2'(rd);
        rs_sel = 2'(rs);
        shamt  = 3'(sh);
        ex_btn = 1'b0;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        #1;
        ex_btn = 1'b1;
        opcode = 4'($urandom);
        rd_sel = 2'($urandom);
        rs_sel = 2'($urandom);
        shamt  = 3'($urandom);
        repeat (len + gap) @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        rec_t act;
        rec_t exp;
        act = '{busy: busy, done: done, illegal: illegal, a_sel: a_sel, b_reg_sel: b_reg_sel,
                b_sel: B_sel, f_sel: F_sel, write_en: write_en, write_o: write_o};
        if (end_req && !end_ack) begin
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL scoreboard_drain: %0d expected cycles never seen, required 0",
                         exp_q.size());
            end
            end_ack <= 1'b1;
        end else if (mon_en) begin
            checks++;
            if (busy === 1'b1 || illegal === 1'b1) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output t=%0t actual=%h required idle=%h",
                             $time, act, IDLE_REC);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        failures++;
                        $display("FAIL exec_cycle t=%0t actual=%h required=%h",
                                 $time, act, exp);
                    end
                end
            end else if (act !== IDLE_REC) begin
                failures++;
                $display("FAIL idle_outputs t=%0t actual=%h required=%h", $time, act, IDLE_REC);
            end
        end
    end

    initial begin
        int len;
        rstn   = 1'b0;
        ex_btn = 1'b1;
        opcode = 4'd0;
        rd_sel = 2'd0;
        rs_sel = 2'd0;
        shamt  = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        do_instr(1, 2, 0, 0, 1, 1);          // IN rd=2
        do_instr(4, 1, 0, 3, 1, 1);          // SHL rd=1 shamt=3
        do_instr(4, 1, 0, 0, 1, 1);          // SHL shamt=0
        do_instr(8, 3, 0, 0, 1, 1);          // ADD rd=3 rs=0
        do_instr(3, 0, 2, 0, 1, 1);          // MOV rd=0 rs=2
        do_instr(14, 1, 1, 0, 1, 2);         // illegal 1110
        do_instr(1, 3, 1, 0, 10, 2);         // button held low 10 cycles
        do_instr(2, 0, 0, 0, 1, 1);          // OUT
        do_instr(7, 2, 2, 0, 1, 1);          // INCB rd==rs

        // SHR shamt=7 with a second press mid-flight that must be ignored.
        push_expect(5, 2, 1, 7, len);
        opcode = 4'd5;
        rd_sel = 2'd2;
        rs_sel = 2'd1;
        shamt  = 3'd7;
        ex_btn = 1'b0;
        @(negedge clk);
        #1;
        ex_btn = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        opcode = 4'd8;
        rd_sel = 2'd0;
        ex_btn = 1'b0;
        @(negedge clk);
        #1;
        ex_btn = 1'b1;
        repeat (len) @(negedge clk);
        #1;

        // Reset asserted during the second EXEC cycle of SHL shamt=5.
        push_expect(4, 3, 0, 5, len);
        opcode = 4'd4;
        rd_sel = 2'd3;
        rs_sel = 2'd0;
        shamt  = 3'd5;
        ex_btn = 1'b0;
        @(negedge clk);
        #1;
        ex_btn = 1'b1;
        @(negedge clk);
        #1;
        rstn = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        #1;

        for (int i = 0; i < 60; i++) begin
            do_instr(int'($urandom_range(15, 0)), int'($urandom_range(3, 0)),
                     int'($urandom_range(3, 0)), int'($urandom_range(7, 0)),
                     int'($urandom_range(3, 1)), int'($urandom_range(2, 0)));
        end

        repeat (3) @(negedge clk);
        #1;
        end_req = 1'b1;
        repeat (4) @(negedge clk);
        if (!end_ack) begin
            $display("FAIL end_handshake: monitor did not acknowledge");
            $fatal(1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
